// File: rtl/crc10_frame_ctrl.sv
// crc10_frame_ctrl: bit-serial CRC-10 (G = x^10+x^9+x^5+x+1) over 32-bit words, one CRC per frame.
// Latency: crc_valid rises 32 cycles after the accept edge of the last word; 1 word per 33 cycles.
// Backpressure: s_ready only in IDLE; OUT holds crc_out until crc_ready, upstream stalls meanwhile.
// Ports: clk, rst (sync, active-high) | s_valid/s_ready/s_data/s_last word input |
//        crc_valid/crc_ready/crc_out CRC result | frame_words (saturating word count) | busy (not IDLE).
module crc10_frame_ctrl #(
   parameter logic [9:0] INIT = 10'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        s_last,
   output logic        crc_valid,
   input  logic        crc_ready,
   output logic [9:0]  crc_out,
   output logic [15:0] frame_words,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] shreg;
   logic        last_q;
   logic [4:0]  bit_cnt;
   logic [9:0]  crc;
   logic        first_word;
   logic        accept;
   logic        fb;
   logic [9:0]  crc_step;

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      crc_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            busy    = 1'b0;
            if (s_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt == 5'd31) state_nxt = last_q ? OUT : IDLE;
         end
         OUT: begin
            crc_valid = 1'b1;
            if (crc_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept  = s_valid && s_ready;
   assign crc_out = crc;

   // One LFSR step: feedback taps at x^9, x^5, x^1, x^0 of the generator
   assign fb       = crc[9] ^ shreg[0];
   assign crc_step = {crc[8] ^ fb, crc[7:5], crc[4] ^ fb, crc[3:1], crc[0] ^ fb, fb};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc         <= INIT;
         shreg       <= '0;
         last_q      <= 1'b0;
         bit_cnt     <= '0;
         frame_words <= '0;
         first_word  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg   <= s_data;
                  last_q  <= s_last;
                  bit_cnt <= '0;
                  // CRC carries across words; reload only at a frame's first word
                  if (first_word) begin
                     crc         <= INIT;
                     frame_words <= 16'd1;
                     first_word  <= 1'b0;
                  end else if (frame_words != 16'hFFFF) begin
                     frame_words <= frame_words + 16'd1;
                  end
               end
            end
            SHIFT: begin
               shreg   <= {1'b0, shreg[31:1]};
               crc     <= crc_step;
               bit_cnt <= bit_cnt + 5'd1;
            end
            OUT: begin
               if (crc_ready) first_word <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crc10_frame_ctrl.sv
module tb_crc10_frame_ctrl;

   localparam logic [9:0] TB_INIT = 10'h000;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic        crc_valid;
   logic        crc_ready;
   logic [9:0]  crc_out;
   logic [15:0] frame_words;
   logic        busy;

   crc10_frame_ctrl #(.INIT(TB_INIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .crc_valid   (crc_valid),
      .crc_ready   (crc_ready),
      .crc_out     (crc_out),
      .frame_words (frame_words),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] fw [16];
   int          acc_cyc = 0;
   int          prev_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // CRC as the remainder of polynomial long division over the serial bit stream
   function automatic logic [9:0] ref_crc(input int n);
      int r;
      r = int'(TB_INIT);
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 32; b++) begin
            r = (r << 1) ^ (int'(fw[i][b]) << 10);
            if ((r & 32'h400) != 0) r = r ^ 32'h623;
         end
      end
      return r[9:0];
   endfunction

   task automatic put_word(input logic [31:0] d, input logic last, input bit chk_gap);
      int t;
      t = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!s_ready && t < 100) begin
         tick();
         t++;
      end
      if (!s_ready) chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
      tick();
      prev_acc = acc_cyc;
      acc_cyc  = cyc;
      if (chk_gap) chk("b2b_gap", acc_cyc - prev_acc, 33);
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_crc();
      int t;
      t = 0;
      // while shifting the last word, input noise must be ignored
      while (!crc_valid && t < 100) begin
         s_valid   = 1'($urandom_range(0, 1));
         s_data    = $urandom;
         s_last    = 1'($urandom_range(0, 1));
         crc_ready = 1'($urandom_range(0, 1));
         tick();
         t++;
      end
      s_valid   = 1'b0;
      crc_ready = 1'b0;
      if (!crc_valid) chk("crc_valid_timeout", {31'd0, crc_valid}, 32'd1);
   endtask

   task automatic run_frame(input int n, input int hold, input logic [9:0] exp_crc, input bit b2b);
      for (int i = 0; i < n; i++) begin
         put_word(fw[i], (i == n - 1), b2b && (i > 0));
         if (i != n - 1 && !b2b) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 40)) tick();
         end
      end
      wait_crc();
      chk("valid_latency", cyc - acc_cyc, 32);
      chk("crc_out", {22'd0, crc_out}, {22'd0, exp_crc});
      chk("frame_words", {16'd0, frame_words}, n);
      for (int h = 0; h < hold; h++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = $urandom;
         tick();
         chk("hold_valid", {31'd0, crc_valid}, 32'd1);
         chk("hold_crc", {22'd0, crc_out}, {22'd0, exp_crc});
         chk("hold_s_ready", {31'd0, s_ready}, 32'd0);
         chk("hold_words", {16'd0, frame_words}, n);
      end
      s_valid   = 1'b0;
      crc_ready = 1'b1;
      tick();
      crc_ready = 1'b0;
      chk("post_valid", {31'd0, crc_valid}, 32'd0);
      chk("post_s_ready", {31'd0, s_ready}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; crc_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      chk("rst_frame_words", {16'd0, frame_words}, 32'd0);
      chk("rst_crc_out", {22'd0, crc_out}, {22'd0, TB_INIT});

      // directed frames
      fw[0] = 32'h0000_0000; run_frame(1, 0, 10'h000, 1'b0);
      fw[0] = 32'h8000_0000; run_frame(1, 0, 10'h223, 1'b0);
      fw[0] = 32'h4000_0000; run_frame(1, 0, 10'h265, 1'b0);
      fw[0] = 32'h8000_0000; run_frame(1, 0, 10'h223, 1'b0);
      fw[0] = 32'h0000_0000; fw[1] = 32'h8000_0000; run_frame(2, 0, 10'h223, 1'b1);
      fw[0] = 32'h8000_0000; run_frame(1, 10, 10'h223, 1'b0);

      // reset in the middle of shifting
      put_word($urandom, 1'b1, 1'b0);
      s_valid = 1'b0;
      repeat (15) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midshift_busy", {31'd0, busy}, 32'd0);
      chk("midshift_s_ready", {31'd0, s_ready}, 32'd1);
      chk("midshift_crc_valid", {31'd0, crc_valid}, 32'd0);
      chk("midshift_words", {16'd0, frame_words}, 32'd0);
      fw[0] = 32'h8000_0000; run_frame(1, 0, 10'h223, 1'b0);

      // reset while the CRC is presented, coinciding with crc_ready
      put_word(32'h1234_5678, 1'b1, 1'b0);
      s_valid = 1'b0;
      wait_crc();
      rst = 1'b1; crc_ready = 1'b1;
      tick();
      rst = 1'b0; crc_ready = 1'b0;
      chk("midout_crc_valid", {31'd0, crc_valid}, 32'd0);
      chk("midout_s_ready", {31'd0, s_ready}, 32'd1);
      chk("midout_words", {16'd0, frame_words}, 32'd0);
      repeat (3) begin
         tick();
         chk("midout_no_pulse", {31'd0, crc_valid}, 32'd0);
      end

      // reset wins over a simultaneous accept
      s_valid = 1'b1; s_data = 32'hFFFF_FFFF; s_last = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; s_valid = 1'b0;
      chk("rst_prio_busy", {31'd0, busy}, 32'd0);
      chk("rst_prio_words", {16'd0, frame_words}, 32'd0);

      // randomized frames against the division model
      repeat (25) begin
         int n;
         int hold;
         bit b2b;
         n    = $urandom_range(1, 4);
         hold = $urandom_range(0, 4);
         b2b  = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) fw[i] = $urandom;
         run_frame(n, hold, ref_crc(n), b2b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
